// File: rtl/io_hub.sv
// io_hub: button-gated user input with a debounced handshake, plus a buffered
// output FIFO towards the display. Drives the await stall used by the timer.
module io_hub #(
    parameter int DATA_W     = 32,
    parameter int IN_W       = 14,
    parameter int DEPTH      = 4,
    parameter int DEB_CYCLES = 4,
    parameter int SIGNED_IN  = 0
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     step_i,
    input  logic                     inop_i,
    input  logic                     outop_i,
    input  logic [DATA_W-1:0]        cpu_data_i,
    input  logic                     bt_i,
    input  logic [IN_W-1:0]          in_i,
    output logic [DATA_W-1:0]        du_o,
    output logic                     await_o,
    output logic                     out_valid_o,
    output logic [DATA_W-1:0]        out_data_o,
    input  logic                     out_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        ACK,
        WAIT_REL
    } inState_e;

    logic [DEB_CYCLES-1:0] deb_q;
    logic                  level_q;
    logic                  press;

    inState_e              state_q;
    logic [DATA_W-1:0]     du_q;
    logic [DATA_W-1:0]     inExt;
    logic                  inputStall;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]         wrPtr_q, wrPtr_d;
    logic [AW-1:0]         rdPtr_q, rdPtr_d;
    logic [AW:0]           count_q, count_d;
    logic [DATA_W-1:0]     outData_q, outData_d;
    logic [DATA_W-1:0]     headNext;
    logic                  full;
    logic                  outValid;
    logic                  push;
    logic                  pop;

    // The level flips the edge after the window is uniform, so this is a single-cycle pulse.
    assign press = (&deb_q) & ~level_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            deb_q   <= '0;
            level_q <= 1'b0;
        end else begin
            deb_q <= {deb_q[DEB_CYCLES-2:0], bt_i};
            if (&deb_q) begin
                level_q <= 1'b1;
            end else if (~|deb_q) begin
                level_q <= 1'b0;
            end
        end
    end

    assign inExt = (SIGNED_IN != 0) ? DATA_W'($signed(in_i)) : DATA_W'(in_i);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            du_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inop_i) begin
                        state_q <= WAIT_PRESS;
                    end
                end
                WAIT_PRESS: begin
                    if (press) begin
                        du_q    <= inExt;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if (step_i) begin
                        state_q <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (!level_q) begin
                        state_q <= inop_i ? WAIT_PRESS : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A new IN arriving while the button is still held must not commit on the
    // stale press, so it stalls here and hands over to WAIT_PRESS without a gap.
    assign inputStall = (state_q == WAIT_PRESS) || ((state_q == WAIT_REL) && inop_i);

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign outValid = (count_q != '0);
    assign push     = step_i & outop_i & ~full;
    assign pop      = out_ready_i & outValid;

    always_comb begin
        wrPtr_d   = push ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d   = pop ? rdPtr_q + 1'b1 : rdPtr_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // The entry becoming head may be the one written this very cycle.
        headNext  = (push && (wrPtr_q == rdPtr_d)) ? cpu_data_i : mem_q[rdPtr_d];
        outData_d = outData_q;
        if (pop || (push && (count_q == '0))) begin
            outData_d = headNext;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wrPtr_q] <= cpu_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            outData_q <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            outData_q <= outData_d;
        end
    end

    assign du_o        = du_q;
    assign await_o     = inputStall | (outop_i & full);
    assign out_valid_o = outValid;
    assign out_data_o  = outData_q;
    assign count_o     = count_q;
    assign full_o      = full;

endmodule

// File: tb/tb_io_hub.sv
// tb_io_hub: directed self-checking bench for io_hub; a second instance with
// SIGNED_IN=1 shares the stimulus to cover sign extension.
module tb_io_hub;

    logic        clk = 1'b0;
    logic        reset;
    logic        step;
    logic        inop;
    logic        outop;
    logic [31:0] cpuData;
    logic        bt;
    logic [13:0] inSw;
    logic        outReady;

    logic [31:0] du, outData;
    logic        awaitSig, outValid, full;
    logic [2:0]  count;

    logic [31:0] du2, outData2;
    logic        await2, outValid2, full2;
    logic [2:0]  count2;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    io_hub #(.DATA_W(32), .IN_W(14), .DEPTH(4), .DEB_CYCLES(4), .SIGNED_IN(0)) dut (
        .clk_i(clk), .reset_i(reset), .step_i(step), .inop_i(inop), .outop_i(outop),
        .cpu_data_i(cpuData), .bt_i(bt), .in_i(inSw), .du_o(du), .await_o(awaitSig),
        .out_valid_o(outValid), .out_data_o(outData), .out_ready_i(outReady),
        .count_o(count), .full_o(full)
    );

    io_hub #(.DATA_W(32), .IN_W(14), .DEPTH(4), .DEB_CYCLES(4), .SIGNED_IN(1)) dutSigned (
        .clk_i(clk), .reset_i(reset), .step_i(step), .inop_i(inop), .outop_i(outop),
        .cpu_data_i(cpuData), .bt_i(bt), .in_i(inSw), .du_o(du2), .await_o(await2),
        .out_valid_o(outValid2), .out_data_o(outData2), .out_ready_i(outReady),
        .count_o(count2), .full_o(full2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, then samples 1ns after the rising edge.
    task automatic applyStimulus(input logic stepV, input logic inopV, input logic outopV,
                                 input logic btV, input logic readyV, input logic [31:0] dataV);
        step     = stepV;
        inop     = inopV;
        outop    = outopV;
        bt       = btV;
        outReady = readyV;
        cpuData  = dataV;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; step = 0; inop = 0; outop = 0; cpuData = 0;
        bt = 0; inSw = 0; outReady = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        checkOutput("reset_du", du, 32'h0);
        checkOutput("reset_await", {31'b0, awaitSig}, 32'h0);
        checkOutput("reset_count", {29'b0, count}, 32'h0);
        checkOutput("reset_valid", {31'b0, outValid}, 32'h0);
        checkOutput("reset_full", {31'b0, full}, 32'h0);
        checkOutput("reset_outdata", outData, 32'h0);

        // Asynchronous reset in the middle of a pending IN
        applyStimulus(1, 0, 1, 0, 0, 32'd7);
        checkOutput("pre_reset_count", {29'b0, count}, 32'd1);
        applyStimulus(0, 1, 0, 0, 0, 32'd0);
        checkOutput("wait_press_await", {31'b0, awaitSig}, 32'h1);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_await", {31'b0, awaitSig}, 32'h0);
        checkOutput("async_reset_du", du, 32'h0);
        checkOutput("async_reset_count", {29'b0, count}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Input handshake with glitches before a stable press
        inSw = 14'h2A5;
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("hs_await_start", {31'b0, awaitSig}, 32'h1);
        applyStimulus(0, 1, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("hs_glitch_await", {31'b0, awaitSig}, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 1, 0, 1, 0, 0);
            checkOutput("hs_await_held", {31'b0, awaitSig}, 32'h1);
        end
        applyStimulus(0, 1, 0, 1, 0, 0);
        checkOutput("hs_await_release", {31'b0, awaitSig}, 32'h0);
        checkOutput("hs_du", du, 32'h0000_02A5);
        checkOutput("hs_du_signed", du2, 32'h0000_02A5);
        applyStimulus(0, 1, 0, 1, 0, 0);
        checkOutput("ack_hold_await", {31'b0, awaitSig}, 32'h0);

        // Held button must not satisfy the next IN
        inSw = 14'h3FFF;
        applyStimulus(1, 1, 0, 1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1, 0, 1, 0, 0);
            checkOutput("held_await", {31'b0, awaitSig}, 32'h1);
        end
        checkOutput("held_du", du, 32'h0000_02A5);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            checkOutput("release_await", {31'b0, awaitSig}, 32'h1);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 0, 1, 0, 0);
        end
        checkOutput("second_press_pending", du, 32'h0000_02A5);
        applyStimulus(0, 1, 0, 1, 0, 0);
        checkOutput("second_press_du", du, 32'h0000_3FFF);
        checkOutput("second_press_du_signed", du2, 32'hFFFF_FFFF);
        checkOutput("second_press_await", {31'b0, awaitSig}, 32'h0);
        applyStimulus(1, 1, 0, 1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
        end
        checkOutput("idle_await", {31'b0, awaitSig}, 32'h0);

        // Press outside WAIT_PRESS is ignored
        inSw = 14'h0123;
        for (int k = 0; k < 6; k++) applyStimulus(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 6; k++) applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("ignored_press_du", du, 32'h0000_3FFF);

        // FIFO fill, stall on full, pop, refill, drain
        for (int v = 1; v <= 4; v++) begin
            applyStimulus(1, 0, 1, 0, 0, 32'(v));
        end
        checkOutput("fill_count", {29'b0, count}, 32'd4);
        checkOutput("fill_full", {31'b0, full}, 32'h1);
        checkOutput("fill_head", outData, 32'd1);
        checkOutput("fill_valid", {31'b0, outValid}, 32'h1);
        applyStimulus(0, 0, 1, 0, 0, 32'd5);
        checkOutput("full_await", {31'b0, awaitSig}, 32'h1);
        applyStimulus(1, 0, 1, 0, 0, 32'd99);
        checkOutput("full_no_push", {29'b0, count}, 32'd4);
        checkOutput("drain_head_1", outData, 32'd1);
        applyStimulus(0, 0, 1, 0, 1, 32'd5);
        checkOutput("pop_count", {29'b0, count}, 32'd3);
        checkOutput("pop_await", {31'b0, awaitSig}, 32'h0);
        applyStimulus(1, 0, 1, 0, 0, 32'd5);
        checkOutput("refill_count", {29'b0, count}, 32'd4);
        for (int v = 2; v <= 5; v++) begin
            checkOutput("drain_head", outData, 32'(v));
            applyStimulus(0, 0, 0, 0, 1, 0);
        end
        checkOutput("drained_count", {29'b0, count}, 32'd0);
        checkOutput("drained_valid", {31'b0, outValid}, 32'h0);

        // Simultaneous push and pop at count 2, wrapping the pointers
        applyStimulus(1, 0, 1, 0, 0, 32'd10);
        applyStimulus(1, 0, 1, 0, 0, 32'd11);
        for (int i = 0; i < 8; i++) begin
            checkOutput("pp_head", outData, 32'(10 + i));
            applyStimulus(1, 0, 1, 0, 1, 32'(12 + i));
            checkOutput("pp_count", {29'b0, count}, 32'd2);
        end
        checkOutput("pp_tail_head_18", outData, 32'd18);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("pp_tail_head_19", outData, 32'd19);
        applyStimulus(0, 0, 0, 0, 1, 0);

        // Pop when empty has no effect
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 1, 0);
            checkOutput("empty_pop_count", {29'b0, count}, 32'd0);
            checkOutput("empty_pop_valid", {31'b0, outValid}, 32'h0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
